// File: rtl/mixcol_seq_pkg.sv
// aes_pkg: shared constants, FSM encodings and byte helpers for the MixColumns engine
package aes_pkg;
    localparam int BYTE     = 8;
    localparam int SENTENCE = 16 * BYTE;
    localparam int PASS_FWD = 1;
    localparam int PASS_INV = 3;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XT   = 2'd1;
    localparam logic [1:0] S_COMB = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;
    function automatic logic [BYTE-1:0] state_byte(input logic [SENTENCE-1:0] s, input int k);
        return s[SENTENCE-1-BYTE*k -: BYTE];
    endfunction
    function automatic int col_byte(input int c, input int i);
        return 4 * c + i;
    endfunction
endpackage

// File: rtl/mixcol_seq_if.sv
// mixcol_seq_if: input/output handshake channels of the MixColumns engine
interface mixcol_seq_if;
    import aes_pkg::*;
    logic                in_valid;
    logic                in_ready;
    logic [SENTENCE-1:0] in_state;
    logic                in_inv;
    logic                out_valid;
    logic                out_ready;
    logic [SENTENCE-1:0] out_state;
    modport master (output in_valid, in_state, in_inv, out_ready, input in_ready, out_valid, out_state);
    modport slave  (input in_valid, in_state, in_inv, out_ready, output in_ready, out_valid, out_state);
endinterface

// File: rtl/mixcol_seq_comb.sv
// mixcol_comb: one-column MixColumns combine from precomputed multiples (inverse with MIXCOL_INV_EN)
module mixcol_comb
    import aes_pkg::*;
(
    input  logic [4*BYTE-1:0] a_i,
    input  logic [4*BYTE-1:0] x2_i,
`ifdef MIXCOL_INV_EN
    input  logic [4*BYTE-1:0] x4_i,
    input  logic [4*BYTE-1:0] x8_i,
    input  logic              inv_i,
`endif
    output logic [4*BYTE-1:0] r_o
);
    for (genvar i = 0; i < 4; i++) begin : g_row
        localparam int J = (i + 1) % 4;
        localparam int K = (i + 2) % 4;
        localparam int L = (i + 3) % 4;
        logic [BYTE-1:0] a0, a1, a2, a3, d0, d1, fwd;
        assign a0  = a_i[4*BYTE-1-BYTE*i -: BYTE];
        assign a1  = a_i[4*BYTE-1-BYTE*J -: BYTE];
        assign a2  = a_i[4*BYTE-1-BYTE*K -: BYTE];
        assign a3  = a_i[4*BYTE-1-BYTE*L -: BYTE];
        assign d0  = x2_i[4*BYTE-1-BYTE*i -: BYTE];
        assign d1  = x2_i[4*BYTE-1-BYTE*J -: BYTE];
        assign fwd = d0 ^ d1 ^ a1 ^ a2 ^ a3;
`ifdef MIXCOL_INV_EN
        // 14*a0 ^ 11*a1 ^ 13*a2 ^ 9*a3 built from the x2/x4/x8 banks
        logic [BYTE-1:0] inv;
        assign inv = (x8_i[4*BYTE-1-BYTE*i -: BYTE] ^ x4_i[4*BYTE-1-BYTE*i -: BYTE] ^ d0)
                   ^ (x8_i[4*BYTE-1-BYTE*J -: BYTE] ^ d1 ^ a1)
                   ^ (x8_i[4*BYTE-1-BYTE*K -: BYTE] ^ x4_i[4*BYTE-1-BYTE*K -: BYTE] ^ a2)
                   ^ (x8_i[4*BYTE-1-BYTE*L -: BYTE] ^ a3);
        assign r_o[4*BYTE-1-BYTE*i -: BYTE] = inv_i ? inv : fwd;
`else
        assign r_o[4*BYTE-1-BYTE*i -: BYTE] = fwd;
`endif
    end
endmodule

// File: rtl/mixcol_seq_xtime.sv
// xtime: multiply one byte by {02} modulo the AES polynomial {11B}
module xtime
    import aes_pkg::*;
(
    input  logic [BYTE-1:0] a_i,
    output logic [BYTE-1:0] y_o
);
    assign y_o = {a_i[BYTE-2:0], 1'b0} ^ (a_i[BYTE-1] ? 8'h1b : 8'h00);
endmodule

// File: rtl/mixcol_seq.sv
// mixcol_seq: iterative MixColumns sharing one xtime unit; MIXCOL_INV_EN adds the inverse mode
module mixcol_seq
    import aes_pkg::*;
(
    input logic        clk,
    input logic        rst,
    mixcol_seq_if.slave io
);
`ifdef MIXCOL_INV_EN
    localparam int NBANK = PASS_INV;
`else
    localparam int NBANK = PASS_FWD;
`endif
    logic [1:0]          state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [BYTE-1:0]     src_q [16];
    logic [BYTE-1:0]     prod_q [NBANK][16];
    logic [SENTENCE-1:0] out_q, out_d;
    logic [BYTE-1:0]     xt_in, xt_out;
    logic                accept, last_pass, xt_end;
`ifdef MIXCOL_INV_EN
    logic [1:0]          pass_q, pass_d;
    logic                inv_q;
    assign xt_in     = pass_q == 2'd0 ? src_q[idx_q] : pass_q == 2'd1 ? prod_q[0][idx_q] : prod_q[1][idx_q];
    assign last_pass = pass_q == (inv_q ? 2'(PASS_INV - 1) : 2'(PASS_FWD - 1));
`else
    assign xt_in     = src_q[idx_q];
    assign last_pass = 1'b1;
`endif
    assign accept       = io.in_valid && state_q == S_IDLE;
    assign xt_end       = state_q == S_XT && idx_q == 4'd15;
    assign io.in_ready  = state_q == S_IDLE;
    assign io.out_valid = state_q == S_HOLD;
    assign io.out_state = out_q;

    xtime u_xtime (.a_i(xt_in), .y_o(xt_out));

    for (genvar c = 0; c < 4; c++) begin : g_col
        mixcol_comb u_comb (
            .a_i ({src_q[col_byte(c, 0)], src_q[col_byte(c, 1)], src_q[col_byte(c, 2)], src_q[col_byte(c, 3)]}),
            .x2_i({prod_q[0][col_byte(c, 0)], prod_q[0][col_byte(c, 1)], prod_q[0][col_byte(c, 2)], prod_q[0][col_byte(c, 3)]}),
`ifdef MIXCOL_INV_EN
            .x4_i({prod_q[1][col_byte(c, 0)], prod_q[1][col_byte(c, 1)], prod_q[1][col_byte(c, 2)], prod_q[1][col_byte(c, 3)]}),
            .x8_i({prod_q[2][col_byte(c, 0)], prod_q[2][col_byte(c, 1)], prod_q[2][col_byte(c, 2)], prod_q[2][col_byte(c, 3)]}),
            .inv_i(inv_q),
`endif
            .r_o (out_d[SENTENCE-1-32*c -: 32])
        );
    end

    // FSM sequencing and byte/pass counters; idx wraps to 0 naturally after byte 15
    always_comb begin
        state_d = accept ? S_XT
                : (xt_end && last_pass) ? S_COMB
                : state_q == S_COMB ? S_HOLD
                : (state_q == S_HOLD && io.out_ready) ? S_IDLE
                : state_q;
        idx_d   = state_q == S_XT ? idx_q + 4'd1 : 4'd0;
`ifdef MIXCOL_INV_EN
        pass_d  = accept ? 2'd0 : (xt_end && !last_pass) ? pass_q + 2'd1 : pass_q;
`endif
    end

    // state registers, input capture, xtime product banks and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            out_q   <= '0;
            for (int k = 0; k < 16; k++) src_q[k] <= '0;
            for (int b = 0; b < NBANK; b++)
                for (int k = 0; k < 16; k++) prod_q[b][k] <= '0;
`ifdef MIXCOL_INV_EN
            pass_q  <= '0;
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                for (int k = 0; k < 16; k++) src_q[k] <= state_byte(io.in_state, k);
`ifdef MIXCOL_INV_EN
                inv_q <= io.in_inv;
`endif
            end
`ifdef MIXCOL_INV_EN
            pass_q <= pass_d;
            if (state_q == S_XT) prod_q[pass_q][idx_q] <= xt_out;
`else
            if (state_q == S_XT) prod_q[0][idx_q] <= xt_out;
`endif
            if (state_q == S_COMB) out_q <= out_d;
        end
    end
endmodule

// File: tb/tb_mixcol_seq.sv
// tb_mixcol_seq: scoreboard bench for mixcol_seq with directed FIPS-197 vectors
module tb_mixcol_seq;
    typedef struct {
        logic [127:0] d;
        int           lat;
    } exp_t;

    localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] V2_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam int LAT_FWD = 17;
    localparam int LAT_INV = 49;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    exp_t sb[$];

    mixcol_seq_if io();
    mixcol_seq dut (.clk(clk), .rst(rst), .io(io));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out / unexpected event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d, input logic inv, input logic [127:0] e, input int lat);
        int n = 0;
        while (!io.in_ready && n < 200) begin tick(); n++; end
        if (!io.in_ready) fail_now("send_wait");
        io.in_valid = 1'b1;
        io.in_state = d;
        io.in_inv   = inv;
        sb.push_back('{e, lat});
        tick();
        io.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 300) begin tick(); n++; end
        if (sb.size() > 0) begin
            fail_now("drain");
            sb.delete();
        end
    endtask

    // monitor: latency on the first out_valid cycle, data on each output handshake
    initial begin
        logic prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && io.in_valid && io.in_ready) acc_cyc = cyc + 1;
            if (!rst && io.out_valid && !prev_v) begin
                if (sb.size() == 0) fail_now("unexpected_out_valid");
                else chk("latency", 128'(cyc - acc_cyc), 128'(sb[0].lat));
            end
            if (!rst && io.out_valid && io.out_ready) begin
                if (sb.size() == 0) fail_now("unexpected_handshake");
                else begin
                    chk("out_state", io.out_state, sb[0].d);
                    void'(sb.pop_front());
                end
            end
            prev_v = io.out_valid;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        io.in_valid  = 1'b0;
        io.in_state  = '0;
        io.in_inv    = 1'b0;
        io.out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_in_ready", 128'(io.in_ready), 128'd1);
        chk("reset_out_valid", 128'(io.out_valid), 128'd0);
        chk("reset_out_state", io.out_state, '0);

        // forward vectors with out_ready held high
        io.out_ready = 1'b1;
        send(V1_IN, 1'b0, V1_OUT, LAT_FWD);
        drain();
        send(V2_IN, 1'b0, V2_OUT, LAT_FWD);
        drain();
`ifdef MIXCOL_INV_EN
        send(V1_OUT, 1'b1, V1_IN, LAT_INV);
        drain();
        send(V2_OUT, 1'b1, V2_IN, LAT_INV);
        drain();
`endif

        // backpressure: result held, new offers ignored
        io.out_ready = 1'b0;
        send(V2_IN, 1'b0, V2_OUT, LAT_FWD);
        n = 0;
        while (!io.out_valid && n < 100) begin tick(); n++; end
        if (!io.out_valid) fail_now("bp_wait");
        io.in_valid = 1'b1;
        io.in_state = V1_IN;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_out_valid", 128'(io.out_valid), 128'd1);
            chk("bp_in_ready", 128'(io.in_ready), 128'd0);
            chk("bp_out_state", io.out_state, V2_OUT);
        end
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready", 128'(io.in_ready), 128'd1);
        repeat (20) tick();
        chk("bp_no_accept", 128'(io.out_valid), 128'd0);
        chk("bp_queue_empty", 128'(sb.size()), 128'd0);

        // reset while in XT at idx 7
        send(V1_IN, 1'b0, V1_OUT, LAT_FWD);
        repeat (7) tick();
        sb.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 128'(io.out_valid), 128'd0);
        chk("rst_in_ready", 128'(io.in_ready), 128'd1);
        chk("rst_out_state", io.out_state, '0);
        send('0, 1'b0, '0, LAT_FWD);
        drain();

        // back-to-back with in_valid held high
        io.in_valid = 1'b1;
        io.in_state = V2_IN;
        io.in_inv   = 1'b0;
        sb.push_back('{V2_OUT, LAT_FWD});
        tick();
        io.in_state = V1_IN;
        sb.push_back('{V1_OUT, LAT_FWD});
        n = 1;
        tick();
        while (!io.in_ready && n < 100) begin tick(); n++; end
        chk("b2b_idle_at", 128'(n), 128'(LAT_FWD + 1));
        tick();
        chk("b2b_single_idle", 128'(io.in_ready), 128'd0);
        io.in_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
